// File: rtl/cfu_mac.sv
// Custom-function unit: add, multi-cycle shift-add multiplier, per-channel MAC accumulators.
// Optional signed byte-lane dot product (op 110) is compiled in only when CFU_DOT4_EN is defined.
module cfu_mac #(
    parameter int ACC_CH   = 4,
    parameter int MUL_STEP = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    output logic        stall_o,
    output logic [31:0] rslt_o
);
    localparam int K     = 32 / MUL_STEP;
    localparam int CH_W  = (ACC_CH > 1) ? $clog2(ACC_CH) : 1;
    localparam int CNT_W = $clog2(K);
    localparam logic [CH_W-1:0] CH_MASK = CH_W'(ACC_CH - 1);

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_MUL   = 3'b001;
    localparam logic [2:0] OP_MULHU = 3'b010;
    localparam logic [2:0] OP_MAC   = 3'b011;
    localparam logic [2:0] OP_ACCRD = 3'b100;
    localparam logic [2:0] OP_ACCLD = 3'b101;
    localparam logic [2:0] OP_DOT4  = 3'b110;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state_reg, state_next;

    logic [CH_W-1:0]  ch_sel, ch_reg;
    logic [2:0]       op_reg;
    logic [63:0]      mcand_reg, prod_reg, partial;
    logic [31:0]      mplr_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [31:0]      acc_rd [ACC_CH];
    logic             acc_we;
    logic [CH_W-1:0]  acc_wa;
    logic [31:0]      acc_wd;
    logic [31:0]      mac_sum;
    logic             is_multi, accept;
    logic             unused_bits;

    assign ch_sel      = funct7_i[CH_W-1:0] & CH_MASK;
    assign is_multi    = (funct3_i == OP_MUL) || (funct3_i == OP_MULHU) || (funct3_i == OP_MAC);
    assign accept      = en_i && is_multi && (state_reg == IDLE);
    assign partial     = mcand_reg * 64'(mplr_reg[MUL_STEP-1:0]);
    assign mac_sum     = acc_rd[ch_reg] + prod_reg[31:0];
    assign unused_bits = ^funct7_i;

`ifdef CFU_DOT4_EN
    logic [31:0] lane_prod [4];
    logic [31:0] dot_rslt;
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_prod[gi] = {{24{src1_i[8*gi+7]}}, src1_i[8*gi +: 8]}
                             * {{24{src2_i[8*gi+7]}}, src2_i[8*gi +: 8]};
    end
    assign dot_rslt = acc_rd[ch_sel] + lane_prod[0] + lane_prod[1] + lane_prod[2] + lane_prod[3];
`endif

    // One register per channel so every accumulator can be cleared in a single reset edge.
    for (genvar gi = 0; gi < ACC_CH; gi++) begin : g_acc
        logic [31:0] acc_reg;
        always_ff @(posedge clk_i) begin
            if (!rst_ni)
                acc_reg <= '0;
            else if (acc_we && (acc_wa == CH_W'(gi)))
                acc_reg <= acc_wd;
        end
        assign acc_rd[gi] = acc_reg;
    end

    always_comb begin
        acc_we = 1'b0;
        acc_wa = ch_sel;
        acc_wd = src1_i;
        if (en_i) begin
            if (state_reg == IDLE && funct3_i == OP_ACCLD) begin
                acc_we = 1'b1;
            end else if (state_reg == DONE && op_reg == OP_MAC) begin
                acc_we = 1'b1;
                acc_wa = ch_reg;
                acc_wd = mac_sum;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            prod_reg  <= '0;
            mcand_reg <= '0;
            mplr_reg  <= '0;
            op_reg    <= OP_ADD;
            ch_reg    <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                mcand_reg <= {32'b0, src1_i};
                mplr_reg  <= src2_i;
                prod_reg  <= '0;
                op_reg    <= funct3_i;
                ch_reg    <= ch_sel;
                cnt_reg   <= '0;
            end else if (state_reg == BUSY && en_i) begin
                // Retire MUL_STEP multiplier bits, LSB first.
                prod_reg  <= prod_reg + partial;
                mcand_reg <= mcand_reg << MUL_STEP;
                mplr_reg  <= mplr_reg >> MUL_STEP;
                cnt_reg   <= cnt_reg + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        stall_o    = 1'b0;
        rslt_o     = '0;
        case (state_reg)
            IDLE: begin
                if (en_i && is_multi) begin
                    state_next = BUSY;
                    stall_o    = 1'b1;
                end else if (en_i) begin
                    case (funct3_i)
                        OP_ADD:   rslt_o = src1_i + src2_i;
                        OP_ACCRD: rslt_o = acc_rd[ch_sel];
                        OP_ACCLD: rslt_o = acc_rd[ch_sel];
`ifdef CFU_DOT4_EN
                        OP_DOT4:  rslt_o = dot_rslt;
`endif
                        default:  rslt_o = '0;
                    endcase
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (!en_i)
                    state_next = IDLE;
                else if (cnt_reg == CNT_W'(K - 1))
                    state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
                if (en_i) begin
                    case (op_reg)
                        OP_MUL:   rslt_o = prod_reg[31:0];
                        OP_MULHU: rslt_o = prod_reg[63:32];
                        OP_MAC:   rslt_o = mac_sum;
                        default:  rslt_o = '0;
                    endcase
                end
            end
            default: state_next = IDLE;
        endcase
        if (!rst_ni) begin
            stall_o = 1'b0;
            rslt_o  = '0;
        end
    end
endmodule

// File: tb/tb_cfu_mac.sv
// Randomized bench for cfu_mac against a transaction-level model of the CFU operations.
module tb_cfu_mac;
    localparam int ACC_CH   = 4;
    localparam int MUL_STEP = 1;
    localparam int K        = 32 / MUL_STEP;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] src1, src2;
    logic        stall;
    logic [31:0] rslt;

    always #5 clk = ~clk;

    cfu_mac #(.ACC_CH(ACC_CH), .MUL_STEP(MUL_STEP)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .en_i     (en),
        .funct3_i (funct3),
        .funct7_i (funct7),
        .src1_i   (src1),
        .src2_i   (src2),
        .stall_o  (stall),
        .rslt_o   (rslt)
    );

    int          checks = 0;
    int          errors = 0;
    logic        chk_on = 1'b0;
    logic        chk_stall = 1'b0;
    logic        exp_stall = 1'b0;
    logic [31:0] exp_rslt = '0;
    logic [31:0] m_acc [ACC_CH];

    // Per-cycle comparison of the outputs against the expectations the driver publishes.
    always @(negedge clk) begin
        if (chk_on) begin
            checks++;
            if (rslt !== exp_rslt) begin
                errors++;
                $display("FAIL cycle_rslt t=%0t: got %08h want %08h", $time, rslt, exp_rslt);
            end
            if (chk_stall) begin
                checks++;
                if (stall !== exp_stall) begin
                    errors++;
                    $display("FAIL cycle_stall t=%0t: got %0b want %0b", $time, stall, exp_stall);
                end
            end
        end
    end

`ifdef CFU_DOT4_EN
    function automatic logic [31:0] dot4(input logic [31:0] a, input logic [31:0] b);
        int  s;
        byte x, y;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            x = a[8*i +: 8];
            y = b[8*i +: 8];
            s += int'(x) * int'(y);
        end
        return 32'(s);
    endfunction
`endif

    function automatic logic [31:0] model_result(input logic [2:0] f3, input int ch,
                                                 input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        case (f3)
            3'd0: return a + b;
            3'd1: return p[31:0];
            3'd2: return p[63:32];
            3'd3: return m_acc[ch] + p[31:0];
            3'd4: return m_acc[ch];
            3'd5: return m_acc[ch];
`ifdef CFU_DOT4_EN
            3'd6: return m_acc[ch] + dot4(a, b);
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        en = 1'b0;
        exp_stall = 1'b0;
        exp_rslt = '0;
        chk_stall = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        en = 1'b0;
        exp_stall = 1'b0;
        exp_rslt = '0;
        chk_stall = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        for (int i = 0; i < ACC_CH; i++) m_acc[i] = '0;
        rst_n = 1'b1;
    endtask

    // Issue one instruction and hold it until the result cycle; nst counts stalled cycles seen.
    task automatic run_op(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] got, output int nst);
        int          ch;
        logic [31:0] want;
        ch   = int'(f7) % ACC_CH;
        want = model_result(f3, ch, a, b);
        en = 1'b1; funct3 = f3; funct7 = f7; src1 = a; src2 = b;
        chk_stall = 1'b1;
        nst = 0;
        if (f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd3) begin
            exp_stall = 1'b1;
            exp_rslt  = '0;
            repeat (K + 1) begin
                @(negedge clk);
                if (stall) nst++;
                @(posedge clk);
                #1;
            end
        end
        exp_stall = 1'b0;
        exp_rslt  = want;
        @(negedge clk);
        got = rslt;
        @(posedge clk);
        #1;
        if (f3 == 3'd3) m_acc[ch] = want;
        else if (f3 == 3'd5) m_acc[ch] = a;
        $display("op f3=%0d ch=%0d a=%08h b=%08h -> %08h (stalls %0d)", f3, ch, a, b, got, nst);
    endtask

    // Start a MAC and abandon it by dropping en after 'cycles' held cycles.
    task automatic abort_mac(input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                             input int cycles);
        en = 1'b1; funct3 = 3'd3; funct7 = f7; src1 = a; src2 = b;
        exp_stall = 1'b1; exp_rslt = '0; chk_stall = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        en = 1'b0; exp_rslt = '0; chk_stall = 1'b0;
        @(posedge clk);
        #1;
        chk_stall = 1'b1; exp_stall = 1'b0;
        $display("abort mac ch=%0d after %0d cycles", int'(f7) % ACC_CH, cycles);
    endtask

    logic [31:0] got;
    int          nst;
    logic [2:0]  rf3;

    initial begin
        rst_n = 1'b0; en = 1'b0; funct3 = '0; funct7 = '0; src1 = '0; src2 = '0;
        chk_on = 1'b1;
        do_reset(3);
        idle(1);

        for (int c = 0; c < ACC_CH; c++) begin
            run_op(3'd4, 7'(c), 32'h0, 32'h0, got, nst);
            lit("reset_acc", got, 32'h0);
        end

        run_op(3'd0, 7'd0, 32'hFFFF_FFFF, 32'd2, got, nst);
        lit("add_wrap", got, 32'h0000_0001);

        run_op(3'd1, 7'd0, 32'h1234_5678, 32'h9ABC_DEF0, got, nst);
        lit("mul_lo", got, 32'h242D_2080);
        lit("mul_stall_cycles", 32'(nst), 32'(K + 1));

        run_op(3'd2, 7'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, got, nst);
        lit("mulhu", got, 32'hFFFF_FFFE);

        run_op(3'd5, 7'd2, 32'd10, 32'd0, got, nst);
        lit("accld_ch2_old", got, 32'd0);
        run_op(3'd3, 7'd2, 32'd3, 32'd4, got, nst);
        lit("mac_ch2", got, 32'd22);
        run_op(3'd4, 7'd2, 32'd0, 32'd0, got, nst);
        lit("accrd_ch2", got, 32'd22);
        run_op(3'd4, 7'd0, 32'd0, 32'd0, got, nst);
        lit("accrd_ch0", got, 32'd0);
        run_op(3'd4, 7'd1, 32'd0, 32'd0, got, nst);
        lit("accrd_ch1", got, 32'd0);
        run_op(3'd4, 7'd3, 32'd0, 32'd0, got, nst);
        lit("accrd_ch3", got, 32'd0);
        run_op(3'd3, 7'h46, 32'd2, 32'd3, got, nst);
        lit("mac_ch_modulo", got, 32'd28);

        run_op(3'd5, 7'd0, 32'd5, 32'd0, got, nst);
        run_op(3'd6, 7'd0, 32'h01FF_0203, 32'h0202_0202, got, nst);
`ifdef CFU_DOT4_EN
        lit("dot4", got, 32'h0000_000F);
`else
        lit("dot4_disabled", got, 32'h0);
`endif
        run_op(3'd7, 7'd0, 32'h1234, 32'h5678, got, nst);
        lit("reserved", got, 32'h0);

        // Reset arriving in the fifth BUSY cycle of a MAC.
        run_op(3'd5, 7'd1, 32'h55, 32'd0, got, nst);
        en = 1'b1; funct3 = 3'd3; funct7 = 7'd1; src1 = 32'd7; src2 = 32'd9;
        exp_stall = 1'b1; exp_rslt = '0; chk_stall = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_stall = 1'b0; exp_rslt = '0;
        @(posedge clk);
        #1;
        for (int i = 0; i < ACC_CH; i++) m_acc[i] = '0;
        rst_n = 1'b1;
        idle(1);
        run_op(3'd4, 7'd1, 32'd0, 32'd0, got, nst);
        lit("accrd_after_reset", got, 32'h0);

        run_op(3'd5, 7'd3, 32'h100, 32'd0, got, nst);
        abort_mac(7'd3, 32'd5, 32'd6, 11);
        run_op(3'd4, 7'd3, 32'd0, 32'd0, got, nst);
        lit("abort_busy_nowrite", got, 32'h100);
        abort_mac(7'd3, 32'd5, 32'd6, K + 1);
        run_op(3'd4, 7'd3, 32'd0, 32'd0, got, nst);
        lit("abort_done_nowrite", got, 32'h100);
        run_op(3'd3, 7'd3, 32'd5, 32'd6, got, nst);
        lit("mac_after_abort", got, 32'h11E);

        for (int t = 0; t < 80; t++) begin
            rf3 = 3'($urandom_range(0, 7));
            run_op(rf3, 7'($urandom_range(0, 127)), $urandom, $urandom, got, nst);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end

        idle(2);
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
